// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mixer_pkg
// Description : Shared types, constants and helpers for the time-multiplexed
//               waveform mixer (mixer_mac_scheduler and mixer_mac_unit).
// Contents    : state_e      - scheduler FSM state encoding
//               N_CH_DEFAULT - default number of mixed channels
//               DW           - waveform / gain width
//               UNITY_GAIN   - effective multiplier used for a gain of 0xFF
//               CH_*         - channel slot indices in the packed buses
//               sat8()       - scale by 1/256 and saturate to 8 bits
// Revision    : 1.0 - initial release
// ============================================================================
package mixer_pkg;

  localparam int         N_CH_DEFAULT = 6;
  localparam int         DW           = 8;
  localparam logic [8:0] UNITY_GAIN   = 9'd256;

  // Channel slots, ch0 occupies bits [7:0] of the packed buses
  localparam int CH_SQUARE    = 0;
  localparam int CH_SAW       = 1;
  localparam int CH_TRI       = 2;
  localparam int CH_SINE      = 3;
  localparam int CH_NOISE     = 4;
  localparam int CH_WAVETABLE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Drop the 8 fractional bits (truncation, no rounding) and clamp the
  // integer part to 0xFF. The accumulator is zero-extended to 32 bits by the
  // caller so this works for any accumulator width up to 32.
  function automatic logic [7:0] sat8(input logic [31:0] acc);
    logic [31:0] scaled;
    scaled = acc >> 8;
    return (scaled > 32'd255) ? 8'hFF : scaled[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mixer_mac_unit
// Description : Registered unsigned 8x9 multiply-accumulate. Kept as its own
//               block so the shared multiplier can be swapped for a hard
//               macro without touching the scheduler.
// Ports       : clk   - system clock
//               rst   - asynchronous active-high reset (clears accumulator)
//               clr   - synchronous accumulator clear (wins over en)
//               en    - add a*b into the accumulator on this edge
//               a     - 8-bit unsigned operand (waveform sample)
//               b     - 9-bit unsigned operand (effective gain, 0..256)
//               acc   - accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_mac_unit #(
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       a,
  input  logic [8:0]       b,
  output logic [ACC_W-1:0] acc
);

  logic [16:0]      product;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    product = a * b;
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-17){1'b0}}, product};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/mixer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mixer_mac_scheduler
// Description : Time-multiplexed N-channel waveform mixer. On a sample tick
//               all waveform/gain pairs are snapshotted, then one channel per
//               clock is fed through a shared multiply-accumulate. The sum is
//               scaled by 1/256, saturated to 8 bits and presented with a
//               one-cycle valid strobe.
// Ports       : clk          - system clock
//               rst          - asynchronous active-high reset
//               sample_tick  - one-cycle request for a new mixed sample
//               wave_in      - packed channel waveforms, ch0 in [7:0]
//               gain_in      - packed channel gains, same packing
//               clr_overrun  - clears the sticky overrun flag
//               mixed_out    - saturated mix, held between updates
//               out_valid    - one-cycle pulse when mixed_out updates
//               busy         - high while a sample is being computed
//               overrun      - sticky: a tick arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_mac_scheduler #(
  parameter int N_CH  = mixer_pkg::N_CH_DEFAULT,
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic [N_CH*DW-1:0] wave_in,
  input  logic [N_CH*DW-1:0] gain_in,
  input  logic               clr_overrun,
  output logic [7:0]         mixed_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  import mixer_pkg::*;

  localparam int IDX_W = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [N_CH*DW-1:0] wave_q, wave_d;
  logic [N_CH*DW-1:0] gain_q, gain_d;
  logic [7:0]         mixed_out_q, mixed_out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  // FSM decoded controls
  logic snap_load;
  logic mac_clr;
  logic mac_en;
  logic sample_done;
  logic mac_last;

  logic [DW-1:0]    wave_arr [N_CH];
  logic [DW-1:0]    gain_arr [N_CH];
  logic [DW-1:0]    wave_sel;
  logic [DW-1:0]    gain_sel;
  logic [8:0]       geff_sel;
  logic [ACC_W-1:0] acc;

  // Unpack the snapshot buses so the channel mux is a plain array index
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign wave_arr[i] = wave_q[i*DW +: DW];
    assign gain_arr[i] = gain_q[i*DW +: DW];
  end

  assign mac_last = (ch_idx_q == LAST_IDX);

  // Full-scale gain code 0xFF means exact unity (x256), so a full-scale
  // wave at full gain reaches 0xFF after the 1/256 scaling.
  always_comb begin
    wave_sel = wave_arr[ch_idx_q];
    gain_sel = gain_arr[ch_idx_q];
    geff_sel = (gain_sel == 8'hFF) ? UNITY_GAIN : {1'b0, gain_sel};
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = MAC;
      MAC:     if (mac_last)    state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    snap_load   = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    sample_done = 1'b0;
    case (state_q)
      IDLE: begin
        snap_load = sample_tick;
        mac_clr   = sample_tick;
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
      end
      DONE: begin
        busy        = 1'b1;
        sample_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    wave_d      = snap_load ? wave_in : wave_q;
    gain_d      = snap_load ? gain_in : gain_q;

    ch_idx_d    = ch_idx_q;
    if (snap_load) begin
      ch_idx_d = '0;
    end else if (mac_en) begin
      ch_idx_d = mac_last ? '0 : ch_idx_q + IDX_W'(1);
    end

    mixed_out_d = sample_done ? sat8(32'(acc)) : mixed_out_q;
    out_valid_d = sample_done;

    // A tick that is being ignored sets the flag even if a clear arrives on
    // the same edge, so no overrun event can be lost.
    overrun_d   = overrun_q;
    if (sample_tick && busy) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_idx_q    <= '0;
      wave_q      <= '0;
      gain_q      <= '0;
      mixed_out_q <= 8'h00;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ch_idx_q    <= ch_idx_d;
      wave_q      <= wave_d;
      gain_q      <= gain_d;
      mixed_out_q <= mixed_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  mixer_mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (wave_sel),
    .b   (geff_sel),
    .acc (acc)
  );

  assign mixed_out = mixed_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mixer_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixer_mac_scheduler
// Description : Self-checking bench for mixer_mac_scheduler. A behavioural
//               model (arithmetic mix plus a simple "free from" timeline)
//               predicts every output each cycle; directed cases pin the
//               model with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_mac_scheduler;

  localparam int N_CH = 6;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic               clr_overrun;
  logic [N_CH*DW-1:0] wave_in;
  logic [N_CH*DW-1:0] gain_in;
  logic [7:0]         mixed_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  mixer_mac_scheduler #(
    .N_CH  (N_CH),
    .DW    (DW),
    .ACC_W (19)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .wave_in     (wave_in),
    .gain_in     (gain_in),
    .clr_overrun (clr_overrun),
    .mixed_out   (mixed_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference mix: sum of wave * effective gain, /256, clamp to 255
  function automatic int mix_ref(input logic [N_CH*DW-1:0] w,
                                 input logic [N_CH*DW-1:0] g);
    int sum;
    sum = 0;
    for (int c = 0; c < N_CH; c++) begin
      int wv;
      int gv;
      wv = int'(w[c*DW +: DW]);
      gv = int'(g[c*DW +: DW]);
      if (gv == 255) gv = 256;
      sum += wv * gv;
    end
    sum = sum / 256;
    return (sum > 255) ? 255 : sum;
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural model: an accepted tick at edge e yields a result at edge
  // e+N_CH+1 and the block is free again from edge e+N_CH+2.
  // --------------------------------------------------------------------------
  longint edge_no  = 0;
  longint free_at  = 0;
  longint due      = 0;
  bit     pend     = 1'b0;
  int     pend_val = 0;
  bit     m_valid  = 1'b0;
  int     m_out    = 0;
  bit     m_busy   = 1'b0;
  bit     m_ovr    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no = 0;
      free_at = 0;
      pend    = 1'b0;
      m_valid = 1'b0;
      m_out   = 0;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (pend && edge_no == due) begin
        m_valid = 1'b1;
        m_out   = pend_val;
        pend    = 1'b0;
      end
      if (sample_tick && edge_no >= free_at) begin
        pend     = 1'b1;
        due      = edge_no + N_CH + 1;
        pend_val = mix_ref(wave_in, gain_in);
        free_at  = edge_no + N_CH + 2;
      end else if (sample_tick) begin
        m_ovr = 1'b1;
      end else if (clr_overrun) begin
        m_ovr = 1'b0;
      end
      if (clr_overrun && sample_tick && edge_no + N_CH + 2 == free_at)
        m_ovr = 1'b0;  // tick was accepted this edge, so the clear applies
      m_busy = (edge_no < free_at - 1);
      edge_no++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_valid));
    check("mixed_out", int'(mixed_out), m_out);
    check("busy",      int'(busy),      int'(m_busy));
    check("overrun",   int'(overrun),   int'(m_ovr));
  end

  // Tick once, optionally disturb the inputs right after the tick edge,
  // then require the strobe exactly 7 edges later with the given value.
  task automatic run_mix(input string name,
                         input logic [N_CH*DW-1:0] w,
                         input logic [N_CH*DW-1:0] g,
                         input int exp_out,
                         input bit scramble);
    int cnt;
    @(negedge clk);
    wave_in     = w;
    gain_in     = g;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    if (scramble) begin
      wave_in = ~w;
      gain_in = ~g;
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({name, " latency"}, cnt, 7);
    check({name, " value"}, int'(mixed_out), exp_out);
    @(posedge clk);
    #1;
    check({name, " strobe width"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst         = 1'b1;
    sample_tick = 1'b0;
    clr_overrun = 1'b0;
    wave_in     = '0;
    gain_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mixed_out", int'(mixed_out), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy",      int'(busy),      0);
    check("reset overrun",   int'(overrun),   0);
    @(negedge clk);
    rst = 1'b0;

    // Single channel
    run_mix("ch0 gain FF", {40'h0, 8'hFF}, {40'h0, 8'hFF}, 8'hFF, 1'b0);
    run_mix("ch0 gain 80", {40'h0, 8'hFF}, {40'h0, 8'h80}, 8'h7F, 1'b0);
    run_mix("ch0 gain 40", {40'h0, 8'hFF}, {40'h0, 8'h40}, 8'h3F, 1'b0);

    // Two channels: square and sine
    run_mix("square+sine",
            {8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80},
            {8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80}, 8'h80, 1'b0);
    run_mix("all gain 0", {N_CH{8'hFF}}, {N_CH{8'h00}}, 8'h00, 1'b0);

    // Six-way mix and saturation
    run_mix("six C0 x 2A", {N_CH{8'hC0}}, {N_CH{8'h2A}}, 8'hBD, 1'b0);
    run_mix("ramp unity sat",
            {8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10},
            {N_CH{8'hFF}}, 8'hFF, 1'b0);
    run_mix("all FF unity", {N_CH{8'hFF}}, {N_CH{8'hFF}}, 8'hFF, 1'b0);

    // Snapshot: inputs change right after the tick edge
    run_mix("snapshot", {N_CH{8'hC0}}, {N_CH{8'h2A}}, 8'hBD, 1'b1);

    // Second tick three edges after the first is dropped
    @(negedge clk);
    wave_in     = {N_CH{8'h40}};
    gain_in     = {N_CH{8'h80}};
    sample_tick = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample_tick = (i == 2);
      if (out_valid) nv++;
    end
    check("overrun single strobe", nv, 1);
    check("overrun set", int'(overrun), 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun cleared", int'(overrun), 0);

    // Back-to-back ticks at the minimum period
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
      sample_tick = ((i % 8) == 0) && (i < 32);
      wave_in     = {$urandom(), 16'($urandom())};
      gain_in     = {$urandom(), 16'($urandom())};
    end
    check("back-to-back strobes", nv, 4);
    check("back-to-back no overrun", int'(overrun), 0);

    // Reset in the middle of the MAC phase
    run_mix("pre-reset", {N_CH{8'hFF}}, {N_CH{8'hFF}}, 8'hFF, 1'b0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy before reset", int'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid reset mixed_out", int'(mixed_out), 0);
    check("mid reset busy",      int'(busy),      0);
    check("mid reset out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("no strobe after reset", nv, 0);
    run_mix("after reset", {N_CH{8'hC0}}, {N_CH{8'h2A}}, 8'hBD, 1'b0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      sample_tick = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < N_CH; c++) begin
        wave_in[c*DW +: DW] = 8'($urandom());
        gain_in[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'hFF
                                                          : 8'($urandom());
      end
    end
    @(negedge clk);
    sample_tick = 1'b0;
    clr_overrun = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
